// File: rtl/mux_reg_scan_if.sv
// Channel-select bus for mux_reg_scan. The master drives the channel inputs
// and controls. The slave returns the registered sample and its tags.
interface mux_reg_scan_if #(
  parameter int N = 4,
  parameter int W = 8
) ();
  localparam int SW = $clog2(N);

  logic             en;
  logic             mode;
  logic [SW-1:0]    sel;
  logic [N*W-1:0]   din;
  logic [W-1:0]     q;
  logic [SW-1:0]    q_ch;
  logic             q_valid;
  logic             wrap;

  modport master (
    output en, mode, sel, din,
    input  q, q_ch, q_valid, wrap
  );

  modport slave (
    input  en, mode, sel, din,
    output q, q_ch, q_valid, wrap
  );
endinterface

// File: rtl/mux_reg_scan.sv
// Registered N:1 channel mux with manual select or round-robin scan.
// In scan mode each channel is held for DWELL enabled cycles.
module mux_reg_scan #(
  parameter int N     = 4,
  parameter int W     = 8,
  parameter int DWELL = 1
) (
  input  logic           clk,
  input  logic           rst,
  mux_reg_scan_if.slave  bus
);
  localparam int SW = $clog2(N);
  localparam int NP = 2 ** SW;

  localparam logic [SW:0]   N_EXT      = (SW+1)'(N);
  localparam logic [SW-1:0] LAST_CH    = SW'(N - 1);
  localparam logic [7:0]    DWELL_LAST = 8'(DWELL - 1);

  logic [SW-1:0] ptr;
  logic [7:0]    dcnt;

  // Channels are padded to a power of two so any select value indexes a
  // defined entry. Out-of-range selects never reach q.
  logic [W-1:0] ch [NP];

  for (genvar i = 0; i < NP; i++) begin : g_ch
    if (i < N) begin : g_real
      assign ch[i] = bus.din[i*W +: W];
    end else begin : g_pad
      assign ch[i] = '0;
    end
  end

  // NOTE: every register here is updated with <= so that all of them
  // sample the pre-edge values of ptr and dcnt. Blocking assignments
  // would let later statements see values that were already updated.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.q       <= '0;
      bus.q_ch    <= '0;
      bus.q_valid <= 1'b0;
      bus.wrap    <= 1'b0;
      ptr         <= '0;
      dcnt        <= '0;
    end else if (!bus.en) begin
      bus.q_valid <= 1'b0;
      bus.wrap    <= 1'b0;
    end else if (!bus.mode) begin
      ptr      <= '0;
      dcnt     <= '0;
      bus.wrap <= 1'b0;
      if ({1'b0, bus.sel} < N_EXT) begin
        bus.q       <= ch[bus.sel];
        bus.q_ch    <= bus.sel;
        bus.q_valid <= 1'b1;
      end else begin
        bus.q_valid <= 1'b0;
      end
    end else begin
      bus.q       <= ch[ptr];
      bus.q_ch    <= ptr;
      bus.q_valid <= 1'b1;
      if (dcnt == DWELL_LAST) begin
        dcnt <= '0;
        if (ptr == LAST_CH) begin
          ptr      <= '0;
          bus.wrap <= 1'b1;
        end else begin
          ptr      <= ptr + SW'(1);
          bus.wrap <= 1'b0;
        end
      end else begin
        dcnt     <= dcnt + 8'd1;
        bus.wrap <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_mux_reg_scan.sv
// Directed bench for mux_reg_scan: three instances cover DWELL=2, DWELL=3
// and a non-power-of-two channel count.
module tb_mux_reg_scan;
  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  mux_reg_scan_if #(.N(4), .W(8)) a_if ();
  mux_reg_scan_if #(.N(4), .W(8)) b_if ();
  mux_reg_scan_if #(.N(3), .W(8)) c_if ();

  mux_reg_scan #(.N(4), .W(8), .DWELL(2)) dut_a (.clk(clk), .rst(rst), .bus(a_if.slave));
  mux_reg_scan #(.N(4), .W(8), .DWELL(3)) dut_b (.clk(clk), .rst(rst), .bus(b_if.slave));
  mux_reg_scan #(.N(3), .W(8), .DWELL(1)) dut_c (.clk(clk), .rst(rst), .bus(c_if.slave));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    a_if.din = $urandom; b_if.din = $urandom; c_if.din = 24'($urandom);
    a_if.en = 1'b1; b_if.en = 1'b1; c_if.en = 1'b1;
    a_if.mode = 1'b1; b_if.mode = 1'b1; c_if.mode = 1'b1;
    a_if.sel = 2'd1; b_if.sel = 2'd1; c_if.sel = 2'd1;
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      step();
      checks++; if (a_if.q !== 8'h00) begin errors++; $display("FAIL reset_q cyc%0d got=%h exp=00", k, a_if.q); end
      checks++; if (a_if.q_ch !== 2'd0) begin errors++; $display("FAIL reset_q_ch cyc%0d got=%0d exp=0", k, a_if.q_ch); end
      checks++; if (a_if.q_valid !== 1'b0) begin errors++; $display("FAIL reset_q_valid cyc%0d got=%b exp=0", k, a_if.q_valid); end
      checks++; if (a_if.wrap !== 1'b0) begin errors++; $display("FAIL reset_wrap cyc%0d got=%b exp=0", k, a_if.wrap); end
      checks++; if (c_if.q_valid !== 1'b0) begin errors++; $display("FAIL reset_c_valid cyc%0d got=%b exp=0", k, c_if.q_valid); end
    end
    rst = 1'b0;
    b_if.en = 1'b0; c_if.en = 1'b0;
    step();
    checks++; if (a_if.q_ch !== 2'd0) begin errors++; $display("FAIL post_reset_ch got=%0d exp=0", a_if.q_ch); end
    checks++; if (a_if.q !== a_if.din[7:0]) begin errors++; $display("FAIL post_reset_q got=%h exp=%h", a_if.q, a_if.din[7:0]); end
    checks++; if (a_if.q_valid !== 1'b1) begin errors++; $display("FAIL post_reset_valid got=%b exp=1", a_if.q_valid); end
  endtask

  task automatic test_manual();
    logic [7:0] exp_q [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    a_if.din = 32'h4433_2211; a_if.mode = 1'b0; a_if.en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      a_if.sel = 2'(i);
      step();
      checks++; if (a_if.q !== exp_q[i]) begin errors++; $display("FAIL manual_q sel%0d got=%h exp=%h", i, a_if.q, exp_q[i]); end
      checks++; if (a_if.q_ch !== 2'(i)) begin errors++; $display("FAIL manual_ch sel%0d got=%0d exp=%0d", i, a_if.q_ch, i); end
      checks++; if (a_if.q_valid !== 1'b1) begin errors++; $display("FAIL manual_valid sel%0d got=%b exp=1", i, a_if.q_valid); end
    end
    a_if.en = 1'b0; a_if.sel = 2'd0;
    for (int k = 0; k < 2; k++) begin
      step();
      checks++; if (a_if.q !== 8'h44) begin errors++; $display("FAIL hold_q cyc%0d got=%h exp=44", k, a_if.q); end
      checks++; if (a_if.q_ch !== 2'd3) begin errors++; $display("FAIL hold_ch cyc%0d got=%0d exp=3", k, a_if.q_ch); end
      checks++; if (a_if.q_valid !== 1'b0) begin errors++; $display("FAIL hold_valid cyc%0d got=%b exp=0", k, a_if.q_valid); end
    end
  endtask

  task automatic test_scan_dwell();
    logic [7:0] ch_q [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    a_if.mode = 1'b1; a_if.en = 1'b1;
    for (int k = 0; k < 16; k++) begin
      logic [1:0] exp_ch;
      logic       exp_wrap;
      exp_ch   = 2'((k / 2) % 4);
      exp_wrap = (k == 7) || (k == 15);
      step();
      checks++; if (a_if.q_ch !== exp_ch) begin errors++; $display("FAIL scan_ch edge%0d got=%0d exp=%0d", k, a_if.q_ch, exp_ch); end
      checks++; if (a_if.q !== ch_q[exp_ch]) begin errors++; $display("FAIL scan_q edge%0d got=%h exp=%h", k, a_if.q, ch_q[exp_ch]); end
      checks++; if (a_if.wrap !== exp_wrap) begin errors++; $display("FAIL scan_wrap edge%0d got=%b exp=%b", k, a_if.wrap, exp_wrap); end
      checks++; if (a_if.q_valid !== 1'b1) begin errors++; $display("FAIL scan_valid edge%0d got=%b exp=1", k, a_if.q_valid); end
    end
  endtask

  task automatic test_enable_gaps();
    logic       en_v  [9] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [1:0] exp_ch[9] = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd1, 2'd1, 2'd2};
    b_if.din = 32'hD4C3_B2A1; b_if.mode = 1'b1;
    for (int k = 0; k < 9; k++) begin
      b_if.en = en_v[k];
      step();
      checks++; if (b_if.q_ch !== exp_ch[k]) begin errors++; $display("FAIL gap_ch edge%0d got=%0d exp=%0d", k, b_if.q_ch, exp_ch[k]); end
      checks++; if (b_if.q_valid !== en_v[k]) begin errors++; $display("FAIL gap_valid edge%0d got=%b exp=%b", k, b_if.q_valid, en_v[k]); end
    end
    checks++; if (b_if.q !== 8'hC3) begin errors++; $display("FAIL gap_q got=%h exp=c3", b_if.q); end
    b_if.en = 1'b0;
  endtask

  task automatic test_mode_switch();
    logic [1:0] pre_ch [5] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2};
    logic [1:0] post_ch[3] = '{2'd0, 2'd0, 2'd1};
    a_if.en = 1'b1; a_if.mode = 1'b0; a_if.sel = 2'd0;
    step();
    a_if.mode = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      checks++; if (a_if.q_ch !== pre_ch[k]) begin errors++; $display("FAIL sw_pre_ch edge%0d got=%0d exp=%0d", k, a_if.q_ch, pre_ch[k]); end
    end
    a_if.mode = 1'b0; a_if.sel = 2'd3;
    step();
    checks++; if (a_if.q_ch !== 2'd3) begin errors++; $display("FAIL sw_manual_ch got=%0d exp=3", a_if.q_ch); end
    checks++; if (a_if.q !== 8'h44) begin errors++; $display("FAIL sw_manual_q got=%h exp=44", a_if.q); end
    a_if.mode = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      checks++; if (a_if.q_ch !== post_ch[k]) begin errors++; $display("FAIL sw_post_ch edge%0d got=%0d exp=%0d", k, a_if.q_ch, post_ch[k]); end
    end
    a_if.en = 1'b0;
  endtask

  task automatic test_out_of_range();
    logic [1:0] sel_v [4] = '{2'd2, 2'd3, 2'd3, 2'd1};
    logic [7:0] exp_q [4] = '{8'hC3, 8'hC3, 8'hC3, 8'hB2};
    logic [1:0] exp_ch[4] = '{2'd2, 2'd2, 2'd2, 2'd1};
    logic       exp_v [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    logic [1:0] scan_ch[4] = '{2'd0, 2'd1, 2'd2, 2'd0};
    logic       scan_wr[4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    c_if.din = 24'hC3B2A1; c_if.en = 1'b1; c_if.mode = 1'b0;
    for (int k = 0; k < 4; k++) begin
      c_if.sel = sel_v[k];
      step();
      checks++; if (c_if.q !== exp_q[k]) begin errors++; $display("FAIL oor_q step%0d got=%h exp=%h", k, c_if.q, exp_q[k]); end
      checks++; if (c_if.q_ch !== exp_ch[k]) begin errors++; $display("FAIL oor_ch step%0d got=%0d exp=%0d", k, c_if.q_ch, exp_ch[k]); end
      checks++; if (c_if.q_valid !== exp_v[k]) begin errors++; $display("FAIL oor_valid step%0d got=%b exp=%b", k, c_if.q_valid, exp_v[k]); end
    end
    c_if.mode = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      checks++; if (c_if.q_ch !== scan_ch[k]) begin errors++; $display("FAIL n3_scan_ch edge%0d got=%0d exp=%0d", k, c_if.q_ch, scan_ch[k]); end
      checks++; if (c_if.wrap !== scan_wr[k]) begin errors++; $display("FAIL n3_scan_wrap edge%0d got=%b exp=%b", k, c_if.wrap, scan_wr[k]); end
    end
    c_if.en = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    a_if.en = 1'b0; a_if.mode = 1'b0; a_if.sel = '0; a_if.din = '0;
    b_if.en = 1'b0; b_if.mode = 1'b0; b_if.sel = '0; b_if.din = '0;
    c_if.en = 1'b0; c_if.mode = 1'b0; c_if.sel = '0; c_if.din = '0;
    test_reset();
    test_manual();
    test_scan_dwell();
    test_enable_gaps();
    test_mode_switch();
    test_out_of_range();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mux_reg_scan.md
# mux_reg_scan

Parametrised registered N:1 multiplexer for the datapath, the successor to the single-bit 2:1 mux-plus-flop. It selects one of N W-bit channels and registers the result. In manual mode a select input chooses the channel. In scan mode an internal pointer sweeps all channels round-robin, holding on each for a programmable number of cycles. A valid flag, a channel tag and an end-of-sweep pulse accompany each sample for the downstream logger.

## Interface
- N, default 4: number of input channels, 2..16.
- W, default 8: channel data width, 1..32.
- DWELL, default 1: number of enabled cycles spent on each channel in scan mode, 1..255.
- SW = $clog2(N): width of the select and channel-tag fields (local parameter).

Ports:
- clk  in  1: clock. All state changes on its rising edge.
- rst  in  1: reset. One clock; reset is synchronous and active-high.
- en  in  1: sample enable. Low freezes all state.
- mode  in  1: 0 = manual select, 1 = round-robin scan.
- sel  in  SW: manual channel select. Ignored in scan mode.
- din  in  N*W: flattened channel inputs. Channel i occupies din[i*W +: W].
- q  out  W: registered selected data.
- q_ch  out  SW: channel index that q was taken from.
- q_valid  out  1: q/q_ch were updated on the most recent edge.
- wrap  out  1: one-cycle pulse marking the last sample of a scan sweep.

## Operation
- Internal state:
  - ptr (SW bits): scan pointer.
  - dcnt (8 bits): dwell counter.
- Reset, when rst=1 at an edge; overrides en and mode:
  - q=0, q_ch=0, q_valid=0, wrap=0, ptr=0, dcnt=0.
- en=0 at an edge:
  - q, q_ch, ptr and dcnt hold.
  - q_valid=0, wrap=0.
- Manual mode (mode=0, en=1):
  - sel<N: q<=din[sel], q_ch<=sel, q_valid<=1.
  - sel>=N (possible when N is not a power of 2): q and q_ch hold, q_valid<=0.
  - ptr and dcnt are forced to 0 and wrap<=0, so scan mode always starts at channel 0.
- Scan mode (mode=1, en=1):
  - Sample and tag: q<=din[ptr], q_ch<=ptr, q_valid<=1.
  - If dcnt==DWELL-1: dcnt<=0 and ptr advances (N-1 wraps to 0). Otherwise dcnt<=dcnt+1 and ptr holds.
  - wrap<=1 only on the edge where ptr moves from N-1 to 0; otherwise wrap<=0.
- Mode change scan→manual mid-dwell: the scan position is discarded, and the next scan entry restarts at channel 0 with dcnt=0.
- Mode change manual→scan: the first scan edge samples channel 0.
- en deasserted mid-dwell: dcnt is frozen. The dwell resumes when en returns; idle cycles do not count toward DWELL.
- q is W bits wide with no extension or truncation. The din slice is passed through unchanged.

## Timing
- Latency is one cycle. Inputs sampled at edge k appear on q/q_ch/q_valid after edge k.
- Outputs are purely registered, with no combinational path from any input to any output.
- wrap coincides with the q/q_ch of the final sample of channel N-1 in a sweep.
- Sweep period in scan mode with en held high is N*DWELL cycles, and wrap has the same period.
- A reset asserted mid-sweep takes effect at that edge. The first post-reset scan edge samples channel 0.

## Test plan
- Reset:
  - Stimulus: N=4, W=8. Drive din with random values, en=1, rst=1 for 2 cycles.
  - Required response: q=0, q_ch=0, q_valid=0, wrap=0. After rst drops with mode=1, the first sample has q_ch=0.
- Manual select:
  - Stimulus: din = {8'h44, 8'h33, 8'h22, 8'h11}, mode=0, sel stepping 0,1,2,3 one per cycle.
  - Required response: q = 11, 22, 33, 44 one cycle later, q_ch = sel, q_valid=1. With en=0, q holds and q_valid=0.
- Scan with dwell:
  - Stimulus: N=4, DWELL=2, mode=1, en=1 for 10 edges.
  - Required response: q_ch sequence 0,0,1,1,2,2,3,3,0,0. wrap=1 only alongside the second ch3 sample. Period is 8 cycles.
- Enable gaps:
  - Stimulus: DWELL=3, scan mode. Drop en for 2 cycles after the first sample of ch1.
  - Required response: q_valid=0 during the gap, q_ch stays 1. Two further ch1 samples follow before ch2.
- Mode switch:
  - Stimulus: in scan mode at ptr=2, set mode=0 with sel=3 for 1 cycle, then mode=1.
  - Required response: q_ch=3, then the scan resumes at q_ch=0.
- Out-of-range select:
  - Stimulus: N=3, mode=0, sel=3.
  - Required response: q and q_ch hold their previous values, q_valid=0.
